instr_encoder: RTL and testbench

//  Reverse of the immediate generator: takes decoded fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit imm).

---
 rtl/rv_isa_pkg.sv | 29 ++
 rtl/instr_pack.sv | 86 ++++++++
 rtl/instr_encoder.sv | 124 ++++++++++++
 tb/tb_instr_encoder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// rtl/rv_isa_pkg.sv - RV32I opcode/funct3 constants, encoder state type, immediate range helper
package rv_isa_pkg;

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_I      = 7'h13;
  localparam logic [6:0] OPC_I_LOAD = 7'h03;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_S      = 7'h23;
  localparam logic [6:0] OPC_B      = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } enc_state_e;

  // True when v is representable as an nbits-wide two's complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
    logic [31:0] s;
    s = 32'($signed(v) >>> (nbits - 1));
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational RV32I field packer with immediate scattering
// IMM_RANGE_CHECK_EN: when defined, out-of-range or misaligned immediates are flagged illegal.
module instr_pack
  import rv_isa_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic ok_i;
  logic ok_sh;
  logic ok_b;
  logic ok_j;
  logic ok_u;
  logic is_shift;
  logic [6:0] shift_f7;

`ifdef IMM_RANGE_CHECK_EN
  assign ok_i  = fits_signed(imm_i, 12);
  assign ok_sh = (imm_i[31:5] == '0);
  assign ok_b  = fits_signed(imm_i, 13) && !imm_i[0];
  assign ok_j  = fits_signed(imm_i, 21) && !imm_i[0];
  assign ok_u  = (imm_i[11:0] == '0);
`else
  assign ok_i  = 1'b1;
  assign ok_sh = 1'b1;
  assign ok_b  = 1'b1;
  assign ok_j  = 1'b1;
  assign ok_u  = 1'b1;
`endif

  assign is_shift = (funct3_i == F3_SLL) || (funct3_i == F3_SRX);
  // Only SRAI carries a non-zero funct7; everything else in the shift family is 0x00.
  assign shift_f7 = {1'b0, (funct3_i == F3_SRX) && funct7_i[5], 5'b0};

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_R: begin
        word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      OPC_I: begin
        if (is_shift) begin
          word_o    = {shift_f7, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
          illegal_o = !ok_sh;
        end else begin
          word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
          illegal_o = !ok_i;
        end
      end
      OPC_I_LOAD, OPC_JALR: begin
        word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        illegal_o = !ok_i;
      end
      OPC_S: begin
        word_o    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        illegal_o = !ok_i;
      end
      OPC_B: begin
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], opcode_i};
        illegal_o = !ok_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        word_o    = {imm_i[31:12], rd_i, opcode_i};
        illegal_o = !ok_u;
      end
      OPC_JAL: begin
        word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        illegal_o = !ok_j;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streams packed RV32I words into IMEM with auto-incrementing address
// IMM_RANGE_CHECK_EN: forwarded to instr_pack; enables immediate range/alignment rejection.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned           ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]     START_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [6:0]        i_opcode,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [31:0]       i_imm,
  input  logic              i_addr_load,
  input  logic [ADDR_W-1:0] i_addr_val,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_err,
  input  logic              i_err_clr,
  output logic [15:0]       o_word_cnt
);

  enc_state_e        state_q, state_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [31:0] packed_word;
  logic        illegal;
  logic        req_acc;
  logic        legal_acc;
  logic        wr_hs;

  instr_pack u_pack (
    .opcode_i  (i_opcode),
    .rd_i      (i_rd),
    .rs1_i     (i_rs1),
    .rs2_i     (i_rs2),
    .funct3_i  (i_funct3),
    .funct7_i  (i_funct7),
    .imm_i     (i_imm),
    .word_o    (packed_word),
    .illegal_o (illegal)
  );

  // In FULL the slot frees exactly when IMEM takes the word, enabling 1 word/clk.
  assign o_req_ready = (state_q == EMPTY) ? 1'b1 : i_wr_ready;
  assign req_acc     = i_req_valid && o_req_ready;
  assign legal_acc   = req_acc && !illegal;
  assign wr_hs       = (state_q == FULL) && i_wr_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      EMPTY: begin
        if (legal_acc) begin
          state_d = FULL;
          data_d  = packed_word;
        end
      end
      FULL: begin
        if (wr_hs) begin
          state_d = legal_acc ? FULL : EMPTY;
          if (legal_acc) begin
            data_d = packed_word;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (wr_hs) begin
      ptr_d = ptr_q + ADDR_W'(3'd4);
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end else if (i_addr_load) begin
      ptr_d = i_addr_val & ~ADDR_W'(2'b11);
    end
    if (req_acc && illegal) begin
      err_d = 1'b1;
    end else if (i_err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ptr_q   <= START_ADDR;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_wr_valid = (state_q == FULL);
  assign o_wr_addr  = ptr_q;
  assign o_wr_data  = data_q;
  assign o_err      = err_q;
  assign o_word_cnt = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed and randomized checks of instr_encoder against a field-level reference encoder
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        addr_load;
  logic [31:0] addr_val;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        err;
  logic        err_clr;
  logic [15:0] word_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(32), .START_ADDR(32'h0)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_opcode    (opcode),
    .i_rd        (rd),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .i_funct3    (funct3),
    .i_funct7    (funct7),
    .i_imm       (imm),
    .i_addr_load (addr_load),
    .i_addr_val  (addr_val),
    .o_wr_valid  (wr_valid),
    .i_wr_ready  (wr_ready),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_err       (err),
    .i_err_clr   (err_clr),
    .o_word_cnt  (word_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] im);
    req_valid = 1'b1;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  // Reference encoder: extracts immediate bits arithmetically and places them by ISA format.
  function automatic void ref_enc(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                  input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] im, output logic [31:0] w, output bit ok);
    logic [31:0] regs;
    int si;
    si   = $signed(im);
    regs = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12);
    ok   = 1'b1;
    w    = 32'h0;
    case (op)
      7'h33: w = (32'(f7) << 25) | regs | (32'(d) << 7) | 32'(op);
      7'h13, 7'h03, 7'h67: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          w = (((f3 == 3'd5 && f7[5]) ? 32'h20 : 32'h0) << 25) | ((im % 32) << 20)
              | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
`ifdef IMM_RANGE_CHECK_EN
          ok = (si >= 0) && (si <= 31);
`endif
        end else begin
          w = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
`ifdef IMM_RANGE_CHECK_EN
          ok = (si >= -2048) && (si <= 2047);
`endif
        end
      end
      7'h23: begin
        w = (((im >> 5) & 32'h7F) << 25) | regs | ((im & 32'h1F) << 7) | 32'(op);
`ifdef IMM_RANGE_CHECK_EN
        ok = (si >= -2048) && (si <= 2047);
`endif
      end
      7'h63: begin
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | regs
            | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7) | 32'(op);
`ifdef IMM_RANGE_CHECK_EN
        ok = (si >= -4096) && (si <= 4094) && (si % 2 == 0);
`endif
      end
      7'h37, 7'h17: begin
        w = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
`ifdef IMM_RANGE_CHECK_EN
        ok = (im % 4096) == 0;
`endif
      end
      7'h6F: begin
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 1) << 20)
            | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'(op);
`ifdef IMM_RANGE_CHECK_EN
        ok = (si >= -(1 << 20)) && (si <= (1 << 20) - 2) && (si % 2 == 0);
`endif
      end
      default: begin
        ok = 1'b0;
        w  = 32'h0;
      end
    endcase
  endfunction

  logic [6:0] op_pool [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

  initial begin
    logic [31:0] exp_ptr;
    logic [31:0] m_ptr, m_data, w;
    logic [15:0] m_cnt;
    bit          m_full, m_err, ok, ready_m, hs, acc;

    rst_n = 1'b0; req_valid = 1'b0; addr_load = 1'b0; addr_val = '0;
    wr_ready = 1'b0; err_clr = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_wr_addr", wr_addr, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(word_cnt), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // ADDI x1,x0,-1
    req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    req_valid = 1'b0;
    check("addi_valid", 32'(wr_valid), 32'd1);
    check("addi_data", wr_data, 32'hFFF00093);
    check("addi_addr", wr_addr, 32'h0);
    check("addi_ready_blocked", 32'(req_ready), 32'd0);
    wr_ready = 1'b1;
    #1 check("addi_ready_follow", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("addi_done_valid", 32'(wr_valid), 32'd0);
    check("addi_next_ptr", wr_addr, 32'h4);
    check("addi_cnt", 32'(word_cnt), 32'd1);

    // Back-to-back LUI / SW / BEQ
    req(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    @(negedge clk);
    check("lui_data", wr_data, 32'h123452B7);
    check("lui_addr", wr_addr, 32'h4);
    req(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8);
    @(negedge clk);
    check("sw_data", wr_data, 32'h00512423);
    check("sw_addr", wr_addr, 32'h8);
    req(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    @(negedge clk);
    req_valid = 1'b0;
    check("beq_data", wr_data, 32'hFE208EE3);
    check("beq_addr", wr_addr, 32'hC);
    check("beq_valid", 32'(wr_valid), 32'd1);
    @(negedge clk);
    check("b2b_idle", 32'(wr_valid), 32'd0);
    check("b2b_ptr", wr_addr, 32'h10);
    check("b2b_cnt", 32'(word_cnt), 32'd4);

    // JAL x1,+2048 under backpressure
    wr_ready = 1'b0;
    req(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    @(negedge clk);
    check("jal_data", wr_data, 32'h001000EF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("jal_hold_data", wr_data, 32'h001000EF);
      check("jal_hold_addr", wr_addr, 32'h10);
      check("jal_hold_ready", 32'(req_ready), 32'd0);
      check("jal_hold_cnt", 32'(word_cnt), 32'd4);
    end
    req_valid = 1'b0;
    check("jal_hold_valid", 32'(wr_valid), 32'd1);
    wr_ready = 1'b1;
    @(negedge clk);
    check("jal_rel_valid", 32'(wr_valid), 32'd0);
    check("jal_rel_ptr", wr_addr, 32'h14);
    check("jal_rel_cnt", 32'(word_cnt), 32'd5);

    // ADDI imm=2048: boundary of the I-type range
    req(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    check("addi2048_err", 32'(err), 32'd1);
    check("addi2048_novalid", 32'(wr_valid), 32'd0);
    check("addi2048_ptr", wr_addr, 32'h14);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_ptr = 32'h14;
`else
    check("addi2048_data", wr_data, 32'h80000013);
    check("addi2048_valid", 32'(wr_valid), 32'd1);
    check("addi2048_err", 32'(err), 32'd0);
    @(negedge clk);
    exp_ptr = 32'h18;
`endif
    check("addi2048_after_ptr", wr_addr, exp_ptr);

    // Unknown opcode, error clear, and error-wins-over-clear
    req(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("badop_err", 32'(err), 32'd1);
    check("badop_novalid", 32'(wr_valid), 32'd0);
    check("badop_ptr", wr_addr, exp_ptr);
    check("badop_ready", 32'(req_ready), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("errclr", 32'(err), 32'd0);
    req(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; err_clr = 1'b0;
    check("err_wins_clr", 32'(err), 32'd1);

    // Pointer load and wrap, then reset while FULL
    addr_load = 1'b1; addr_val = 32'hFFFF_FFFF;
    @(negedge clk);
    addr_load = 1'b0;
    check("load_ptr", wr_addr, 32'hFFFF_FFFC);
    req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    @(negedge clk);
    check("wrap_addr0", wr_addr, 32'hFFFF_FFFC);
    check("wrap_data0", wr_data, 32'h00100093);
    req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    @(negedge clk);
    req_valid = 1'b0; wr_ready = 1'b0;
    check("wrap_addr1", wr_addr, 32'h0);
    check("wrap_data1", wr_data, 32'h00200093);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(wr_valid), 32'd0);
    check("arst_data", wr_data, 32'h0);
    check("arst_addr", wr_addr, 32'h0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_cnt", 32'(word_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model
    m_ptr = 32'h0; m_cnt = 16'd0; m_full = 1'b0; m_data = 32'h0; m_err = 1'b0;
    for (int n = 0; n < 500; n++) begin
      check("rnd_valid", 32'(wr_valid), 32'(m_full));
      if (m_full) check("rnd_data", wr_data, m_data);
      check("rnd_addr", wr_addr, m_ptr);
      check("rnd_err", 32'(err), 32'(m_err));
      check("rnd_cnt", 32'(word_cnt), 32'(m_cnt));

      req_valid = ($urandom_range(0, 3) != 0);
      wr_ready  = ($urandom_range(0, 3) != 0);
      opcode    = op_pool[$urandom_range(0, 9)];
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3 = 3'($urandom); funct7 = 7'($urandom);
      case ($urandom_range(0, 2))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        default: imm = 32'($urandom_range(0, 31));
      endcase
      addr_load = ($urandom_range(0, 15) == 0);
      addr_val  = $urandom;
      err_clr   = ($urandom_range(0, 7) == 0);
      #1;
      ready_m = !m_full || wr_ready;
      check("rnd_req_ready", 32'(req_ready), 32'(ready_m));
      hs  = m_full && wr_ready;
      acc = req_valid && ready_m;
      ref_enc(opcode, rd, rs1, rs2, funct3, funct7, imm, w, ok);
      if (hs) begin
        m_ptr  = m_ptr + 32'd4;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_full = 1'b0;
      end else if (addr_load) begin
        m_ptr = addr_val & ~32'd3;
      end
      if (acc && ok) begin
        m_full = 1'b1;
        m_data = w;
      end
      if (acc && !ok) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
